// File: rtl/tdm_demux_if.sv
// Bus bundle between a TDM link source and the demultiplexer.
// The master drives the serial samples and the slave returns the published frames.
interface tdm_demux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               frame_start;
  logic [N*WIDTH-1:0] dout;
  logic               frame_valid;
  logic               frame_err;
  logic [SEL_W-1:0]   ch_sel;

  modport master (
    output din, din_valid, frame_start,
    input  dout, frame_valid, frame_err, ch_sel
  );

  modport slave (
    input  din, din_valid, frame_start,
    output dout, frame_valid, frame_err, ch_sel
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects N serial samples into shadow registers
// and publishes the whole frame atomically with a one-cycle strobe.
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  state_t             state;
  logic [SEL_W-1:0]   cnt;
  logic [WIDTH-1:0]   shadow [N];
  logic [N*WIDTH-1:0] doutReg;
  logic               frameValid;
  logic               frameErr;

  // cnt is held at 0 whenever the FSM is in IDLE, so it doubles as ch_sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      doutReg    <= '0;
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          IDLE: begin
            if (bus.frame_start) begin
              shadow[0] <= bus.din;
              cnt       <= SEL_W'(1);
              state     <= RECV;
            end else begin
              frameErr <= 1'b1;
            end
          end
          RECV: begin
            if (bus.frame_start) begin
              frameErr  <= 1'b1;
              shadow[0] <= bus.din;
              cnt       <= SEL_W'(1);
            end else begin
              shadow[cnt] <= bus.din;
              if (cnt == LAST) begin
                // The last channel comes straight from din; the shadow copy lands too late.
                for (int k = 0; k < N - 1; k++) begin
                  doutReg[k*WIDTH +: WIDTH] <= shadow[k];
                end
                doutReg[(N-1)*WIDTH +: WIDTH] <= bus.din;
                frameValid <= 1'b1;
                cnt        <= '0;
                state      <= IDLE;
              end else begin
                cnt <= cnt + SEL_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.dout        = doutReg;
  assign bus.frame_valid = frameValid;
  assign bus.frame_err   = frameErr;
  assign bus.ch_sel      = cnt;

endmodule
